// File: rtl/mem_stage.sv
// RV32I memory stage: issues one aligned data-memory access per load/store,
// stalls EX while the access is outstanding, and produces the writeback beat.
module mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic [1:0]      ex_wb_sel,
  input  logic [XLEN-1:0] ex_pc_plus4,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            misaligned_exc,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              misaligned_exc_q, misaligned_exc_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [2:0]        acc_funct3_q, acc_funct3_d;
  logic [1:0]        acc_addr_lo_q, acc_addr_lo_d;
  logic [4:0]        acc_rd_q, acc_rd_d;
  logic              acc_reg_write_q, acc_reg_write_d;

  logic              is_mem_c;
  logic              illegal_c;
  logic [1:0]        addr_lo_c;
  logic [XLEN-1:0]   shifted_c;
  logic [XLEN-1:0]   load_data_c;

  // Decode legality of the memory op presented by EX.
  always_comb begin
    addr_lo_c = ex_alu_result[1:0];
    is_mem_c  = ex_mem_read | ex_mem_write;
    illegal_c = 1'b0;
    if (ex_mem_read && ex_mem_write) illegal_c = 1'b1;
    if (ex_mem_read && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111))
      illegal_c = 1'b1;
    if (ex_mem_write && ex_funct3 > 3'b010) illegal_c = 1'b1;
    if (ex_funct3[1:0] == 2'b01 && addr_lo_c[0]) illegal_c = 1'b1;
    if (ex_funct3[1:0] == 2'b10 && addr_lo_c != 2'b00) illegal_c = 1'b1;
  end

  // Halves are always aligned here, so one byte-granular shift serves every width.
  always_comb begin
    shifted_c = dmem_rdata >> {acc_addr_lo_q, 3'b000};
    case (acc_funct3_q)
      3'b000:  load_data_c = {{(XLEN-BYTE_W){shifted_c[BYTE_W-1]}}, shifted_c[BYTE_W-1:0]};
      3'b001:  load_data_c = {{(XLEN-HALF_W){shifted_c[HALF_W-1]}}, shifted_c[HALF_W-1:0]};
      3'b100:  load_data_c = {{(XLEN-BYTE_W){1'b0}}, shifted_c[BYTE_W-1:0]};
      3'b101:  load_data_c = {{(XLEN-HALF_W){1'b0}}, shifted_c[HALF_W-1:0]};
      default: load_data_c = shifted_c;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wdata_d     = dmem_wdata_q;
    dmem_be_d        = dmem_be_q;
    wb_valid_d       = 1'b0;
    misaligned_exc_d = 1'b0;
    wb_reg_write_d   = wb_reg_write_q;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    acc_funct3_d     = acc_funct3_q;
    acc_addr_lo_d    = acc_addr_lo_q;
    acc_rd_d         = acc_rd_q;
    acc_reg_write_d  = acc_reg_write_q;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem_c) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = ex_rd;
            wb_reg_write_d = ex_reg_write && (ex_rd != 5'd0);
            case (ex_wb_sel)
              2'b00:   wb_data_d = ex_alu_result;
              2'b10:   wb_data_d = ex_pc_plus4;
              default: wb_data_d = '0;
            endcase
          end else if (illegal_c) begin
            wb_valid_d       = 1'b1;
            misaligned_exc_d = 1'b1;
            wb_reg_write_d   = 1'b0;
            wb_rd_d          = ex_rd;
          end else begin
            state_d         = ACCESS;
            dmem_req_d      = 1'b1;
            dmem_we_d       = ex_mem_write;
            dmem_addr_d     = {ex_alu_result[XLEN-1:2], 2'b00};
            acc_funct3_d    = ex_funct3;
            acc_addr_lo_d   = addr_lo_c;
            acc_rd_d        = ex_rd;
            acc_reg_write_d = ex_reg_write && (ex_rd != 5'd0) && ex_mem_read;
            case (ex_funct3[1:0])
              2'b00: begin
                dmem_be_d    = 4'b0001 << addr_lo_c;
                dmem_wdata_d = {4{ex_store_data[BYTE_W-1:0]}};
              end
              2'b01: begin
                dmem_be_d    = 4'b0011 << addr_lo_c;
                dmem_wdata_d = {2{ex_store_data[HALF_W-1:0]}};
              end
              default: begin
                dmem_be_d    = 4'b1111;
                dmem_wdata_d = ex_store_data;
              end
            endcase
          end
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          state_d        = IDLE;
          dmem_req_d     = 1'b0;
          wb_valid_d     = 1'b1;
          wb_rd_d        = acc_rd_q;
          wb_reg_write_d = acc_reg_write_q;
          if (!dmem_we_q) wb_data_d = load_data_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wdata_q     <= '0;
      dmem_be_q        <= '0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      misaligned_exc_q <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      acc_funct3_q     <= '0;
      acc_addr_lo_q    <= '0;
      acc_rd_q         <= '0;
      acc_reg_write_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      dmem_be_q        <= dmem_be_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_write_q   <= wb_reg_write_d;
      misaligned_exc_q <= misaligned_exc_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      acc_funct3_q     <= acc_funct3_d;
      acc_addr_lo_q    <= acc_addr_lo_d;
      acc_rd_q         <= acc_rd_d;
      acc_reg_write_q  <= acc_reg_write_d;
    end
  end

  assign mem_stall      = (state_q == ACCESS);
  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_be        = dmem_be_q;
  assign wb_valid       = wb_valid_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign misaligned_exc = misaligned_exc_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic [1:0]  ex_wb_sel = '0;
  logic [31:0] ex_pc_plus4 = '0;
  logic        mem_stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_reg_write, misaligned_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel), .ex_pc_plus4(ex_pc_plus4),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .misaligned_exc(misaligned_exc),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic rw, input logic [1:0] sel);
    ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = rw; ex_wb_sel = sel;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({dmem_req, dmem_we, dmem_be, wb_valid, wb_reg_write, misaligned_exc, mem_stall} !== 11'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0",
        {dmem_req, dmem_we, dmem_be, wb_valid, wb_reg_write, misaligned_exc, mem_stall});
    end
    n_tests++;
    if ({dmem_addr, dmem_wdata, wb_data, wb_rd} !== 101'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h rd=%0d", dmem_addr, dmem_wdata, wb_data, wb_rd);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 2'b00);
    tick();
    idle_in();
    n_tests++;
    if ({wb_valid, wb_rd, wb_reg_write, misaligned_exc, dmem_req} !== {1'b1, 5'd5, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_ctrl: valid=%b rd=%0d rw=%b exc=%b req=%b want 1 5 1 0 0",
        wb_valid, wb_rd, wb_reg_write, misaligned_exc, dmem_req);
    end
    n_tests++;
    if (wb_data !== 32'h0000_1234) begin
      n_fail++; $display("FAIL add_data: got %h want 00001234", wb_data);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h0000_1234 || wb_rd !== 5'd5) begin
      n_fail++; $display("FAIL add_hold: valid=%b data=%h rd=%0d want 0 00001234 5", wb_valid, wb_data, wb_rd);
    end
  endtask

  task automatic test_lb();
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2'b01);
    tick();
    idle_in();
    n_tests++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h0000_0100 || mem_stall !== 1'b1) begin
      n_fail++; $display("FAIL lb_req: req=%b we=%b addr=%h stall=%b want 1 0 00000100 1", dmem_req, dmem_we, dmem_addr, mem_stall);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || wb_valid !== 1'b0 || dmem_addr !== 32'h0000_0100) begin
        n_fail++; $display("FAIL lb_wait%0d: stall=%b req=%b valid=%b addr=%h want 1 1 0 00000100",
          i, mem_stall, dmem_req, wb_valid, dmem_addr);
      end
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h80FF_FF00;
    tick();
    dmem_ready = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80 || wb_rd !== 5'd7 || wb_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL lb_wb: valid=%b data=%h rd=%0d rw=%b want 1 ffffff80 7 1", wb_valid, wb_data, wb_rd, wb_reg_write);
    end
    n_tests++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL lb_release: req=%b stall=%b want 0 0", dmem_req, mem_stall);
    end
    tick();
    n_tests++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL lb_pulse: valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_sh();
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd3, 1'b1, 2'b00);
    tick();
    idle_in();
    n_tests++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL sh_req: req=%b we=%b be=%b addr=%h want 1 1 1100 00000200", dmem_req, dmem_we, dmem_be, dmem_addr);
    end
    n_tests++;
    if (dmem_wdata !== 32'hABCD_ABCD) begin
      n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", dmem_wdata);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || misaligned_exc !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL sh_wb: valid=%b rw=%b exc=%b req=%b want 1 0 0 0", wb_valid, wb_reg_write, misaligned_exc, dmem_req);
    end
    tick();
  endtask

  task automatic test_sb_lanes();
    logic [3:0] exp_be [4];
    exp_be[0] = 4'b0001; exp_be[1] = 4'b0010; exp_be[2] = 4'b0100; exp_be[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 3'b000, 32'h0000_0600 + 32'(i), 32'h1234_56A5, 5'd0, 1'b0, 2'b00);
      tick();
      idle_in();
      dmem_ready = 1'b1;
      n_tests++;
      if (dmem_be !== exp_be[i] || dmem_wdata !== 32'hA5A5_A5A5 || dmem_addr !== 32'h0000_0600) begin
        n_fail++; $display("FAIL sb_lane%0d: be=%b wdata=%h addr=%h want %b a5a5a5a5 00000600",
          i, dmem_be, dmem_wdata, dmem_addr, exp_be[i]);
      end
      tick();
      dmem_ready = 1'b0;
    end
  endtask

  task automatic test_exceptions();
    logic        rd_v [4];
    logic        wr_v [4];
    logic [2:0]  f3_v [4];
    logic [31:0] ad_v [4];
    rd_v[0] = 1; wr_v[0] = 0; f3_v[0] = 3'b010; ad_v[0] = 32'h301;
    rd_v[1] = 1; wr_v[1] = 0; f3_v[1] = 3'b011; ad_v[1] = 32'h300;
    rd_v[2] = 1; wr_v[2] = 1; f3_v[2] = 3'b010; ad_v[2] = 32'h300;
    rd_v[3] = 0; wr_v[3] = 1; f3_v[3] = 3'b001; ad_v[3] = 32'h303;
    for (int i = 0; i < 4; i++) begin
      issue(rd_v[i], wr_v[i], f3_v[i], ad_v[i], 32'h0, 5'd4, 1'b1, 2'b01);
      tick();
      idle_in();
      n_tests++;
      if ({wb_valid, misaligned_exc, wb_reg_write, dmem_req, mem_stall} !== 5'b11000) begin
        n_fail++; $display("FAIL exc%0d: valid/exc/rw/req/stall=%b want 11000", i,
          {wb_valid, misaligned_exc, wb_reg_write, dmem_req, mem_stall});
      end
      tick();
      n_tests++;
      if (misaligned_exc !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++; $display("FAIL exc%0d_clear: exc=%b valid=%b req=%b want 0 0 0", i, misaligned_exc, wb_valid, dmem_req);
      end
    end
  endtask

  task automatic test_lhu();
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 5'd6, 1'b1, 2'b01);
    tick();
    idle_in();
    dmem_ready = 1'b1; dmem_rdata = 32'h8001_0000;
    tick();
    dmem_ready = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_8001 || wb_rd !== 5'd6) begin
      n_fail++; $display("FAIL lhu: valid=%b data=%h rd=%0d want 1 00008001 6", wb_valid, wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_rd0();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd0, 1'b1, 2'b01);
    tick();
    idle_in();
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ready = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rd0: valid=%b rw=%b data=%h want 1 0 deadbeef", wb_valid, wb_reg_write, wb_data);
    end
    tick();
  endtask

  task automatic test_ignore_ready();
    dmem_ready = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    tick();
    dmem_ready = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ready_ignored: valid=%b req=%b stall=%b data=%h want 0 0 0 deadbeef",
        wb_valid, dmem_req, mem_stall, wb_data);
    end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd8, 1'b1, 2'b01);
    tick();
    idle_in();
    n_tests++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: req=%b want 1", dmem_req);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: req=%b stall=%b valid=%b want 0 0 0", dmem_req, mem_stall, wb_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_after%0d: valid=%b req=%b want 0 0", i, wb_valid, dmem_req);
      end
    end
    dmem_ready = 1'b0;
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd9, 1'b1, 2'b00);
    tick();
    idle_in();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0055 || wb_rd !== 5'd9 || wb_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_add: valid=%b data=%h rd=%0d rw=%b want 1 00000055 9 1", wb_valid, wb_data, wb_rd, wb_reg_write);
    end
  endtask

  task automatic test_back_to_back();
    ex_pc_plus4 = 32'h0000_1004;
    issue(1'b0, 1'b0, 3'b000, 32'h0000_00AA, 32'h0, 5'd10, 1'b1, 2'b10);
    tick();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0000_1004 || wb_rd !== 5'd10) begin
      n_fail++; $display("FAIL b2b_first: valid=%b data=%h rd=%0d want 1 00001004 10", wb_valid, wb_data, wb_rd);
    end
    issue(1'b0, 1'b0, 3'b000, 32'h0000_00BB, 32'h0, 5'd11, 1'b1, 2'b11);
    tick();
    idle_in();
    n_tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_rd !== 5'd11) begin
      n_fail++; $display("FAIL b2b_second: valid=%b data=%h rd=%0d want 1 00000000 11", wb_valid, wb_data, wb_rd);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb();
    test_sh();
    test_sb_lanes();
    test_exceptions();
    test_lhu();
    test_rd0();
    test_ignore_ready();
    test_reset_mid_access();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter XLEN, 32, datapath/address width; only 32 is supported.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  EX stage presents an instruction this cycle.
REQ-005 ex_alu_result  in  XLEN  ALU result; effective address for loads/stores.
REQ-006 ex_store_data  in  XLEN  rs2 value for stores.
REQ-007 ex_mem_read / ex_mem_write  in  1 each  load / store.
REQ-008 ex_funct3  in  3  RV32I width/sign code.
REQ-009 ex_rd  in  5; ex_reg_write  in  1; ex_wb_sel  in  2 (00 ALU, 01 load, 10 pc+4, 11 zero); ex_pc_plus4  in  XLEN.
REQ-010 mem_stall  out  1  EX must hold its outputs and must not advance.
REQ-011 dmem_req, dmem_we  out  1; dmem_addr  out  XLEN (bits[1:0]=0); dmem_wdata  out  XLEN; dmem_be  out  4.
REQ-012 dmem_ready  in  1; dmem_rdata  in  XLEN (valid when dmem_ready).
REQ-013 wb_valid, wb_reg_write, misaligned_exc  out  1; wb_rd  out  5; wb_data  out  XLEN.

Function
REQ-014 FSM states are IDLE and ACCESS; all outputs except mem_stall are registered.
REQ-015 mem_stall = (state==ACCESS); IDLE accepts ex_valid every cycle; ex_valid is ignored in ACCESS.
REQ-016 Non-memory op accepted at edge T: wb_valid=1 for exactly the cycle after T, wb_data per ex_wb_sel, wb_rd=ex_rd.
REQ-017 Legal memory op accepted in IDLE: go to ACCESS; dmem_req=1 from the next cycle with addr/we/be/wdata stable until dmem_ready sampled 1.
REQ-018 On dmem_ready in ACCESS: dmem_req drops next cycle, state returns to IDLE, wb_valid pulses one cycle; minimum load/store latency 2 cycles after acceptance.
REQ-019 dmem_addr = {addr[31:2],2'b00}.
REQ-020 Store be: SB(000)=4'b0001<<addr[1:0], wdata=byte replicated x4; SH(001)=4'b0011<<addr[1:0], wdata=half replicated x2; SW(010)=4'b1111.
REQ-021 Load extract by addr[1:0]: LB(000)/LH(001) sign-extend, LBU(100)/LHU(101) zero-extend, LW(010) full word.
REQ-022 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), illegal funct3 (load 011/110/111, store >010), or read&write both set: no dmem_req, no ACCESS; next cycle wb_valid=1, misaligned_exc=1, wb_reg_write=0.
REQ-023 misaligned_exc is 1 only in that same cycle as wb_valid.
REQ-024 wb_reg_write = ex_reg_write & (ex_rd!=0) & !exception; stores always give wb_reg_write=0.
REQ-025 ex_valid=0 in IDLE: wb_valid=0 next cycle; all other wb outputs hold.
REQ-026 dmem_ready while not requesting is ignored.

Reset
REQ-027 reset=1 forces immediately: state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, wb_valid=0, wb_reg_write=0, misaligned_exc=0, mem_stall=0, all data/address/rd outputs 0.
REQ-028 reset asserted during ACCESS abandons the access; no wb_valid is produced for it after release.
REQ-029 First acceptance occurs at the first rising edge with reset=0.

Verification
REQ-030 ADD rd=5, alu=0x0000_1234, wb_sel=00 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, wb_reg_write=1, no dmem_req.
REQ-031 LB addr=0x103, dmem_ready after 3 wait cycles, rdata=0x80FF_FF00 -> dmem_addr=0x100, mem_stall=1 throughout ACCESS, wb_data=0xFFFF_FF80 the cycle after ready.
REQ-032 SH addr=0x202, rs2=0x0000_ABCD, ready=1 immediately -> dmem_we=1, be=4'b1100, wdata=0xABCD_ABCD, wb_valid=1 with wb_reg_write=0.
REQ-033 LW addr=0x301 -> no dmem_req, next cycle wb_valid=1, misaligned_exc=1, wb_reg_write=0; LHU at 0x302 with rdata=0x8001_0000 -> wb_data=0x0000_8001.
REQ-034 Load with rd=0 -> wb_reg_write=0; reset pulse mid-ACCESS -> dmem_req=0 immediately, no wb_valid after release, next ADD completes normally.
